// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MULT/MULTU/DIV/DIVU engine returning {hi, lo}; optional
// single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
`timescale 1ns/1ps
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               dz_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_div, r_quick, r_negq, r_negr, r_ready, r_dz;
  logic [W2-1:0] r_acc, r_res;
  logic [WIDTH-1:0] r_b;
  logic w_s1, w_s2, w_dz, w_fast, w_ge;
  logic [WIDTH-1:0] w_m1, w_m2, w_q, w_r, w_sub;
  logic [WIDTH:0] w_sh, w_add;
  logic [W2-1:0] w_div_nx, w_mul_nx, w_div_res, w_mul_res, w_fast_res, w_final;
  assign w_s1 = op_i[0] & opdata1_i[WIDTH-1];
  assign w_s2 = op_i[0] & opdata2_i[WIDTH-1];
  assign w_m1 = w_s1 ? -opdata1_i : opdata1_i;
  assign w_m2 = w_s2 ? -opdata2_i : opdata2_i;
  assign w_dz = op_i[1] && (opdata2_i == '0);
  // r_acc holds {remainder, dividend/quotient} for divide, {partial product, multiplier} for multiply
  assign w_sh = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge = w_sh >= {1'b0, r_b};
  assign w_sub = w_sh[WIDTH-1:0] - r_b;
  assign w_div_nx = {w_ge ? w_sub : w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  assign w_add = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_b};
  assign w_mul_nx = {w_add, r_acc[WIDTH-1:1]};
  assign w_q = r_acc[WIDTH-1:0];
  assign w_r = r_acc[W2-1:WIDTH];
  assign w_div_res = {r_negr ? -w_r : w_r, r_negq ? -w_q : w_q};
  assign w_mul_res = r_negq ? -r_acc : r_acc;
`ifdef MULDIV_FAST_MUL_EN
  // fast path keeps raw operands in r_acc and uses r_negq as the signed-op flag
  assign w_fast = ~op_i[1];
  assign w_fast_res = W2'($signed({r_negq & r_acc[W2-1], r_acc[W2-1:WIDTH]}) *
                          $signed({r_negq & r_acc[WIDTH-1], r_acc[WIDTH-1:0]}));
`else
  assign w_fast = 1'b0;
  assign w_fast_res = w_mul_res;
`endif
  assign w_final = r_quick ? (r_div ? {w_q, {WIDTH{1'b1}}} : w_fast_res)
                           : (r_div ? w_div_res : w_mul_res);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_quick <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_acc   <= '0;
      r_b     <= '0;
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
      r_res   <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i && !annul_i) begin
          r_state <= S_RUN;
          r_cnt   <= '0;
          r_div   <= op_i[1];
          r_quick <= w_dz | w_fast;
          r_negq  <= w_fast ? op_i[0] : w_s1 ^ w_s2;
          r_negr  <= w_s1;
          r_b     <= op_i[1] ? w_m2 : w_m1;
          r_acc   <= w_fast ? {opdata1_i, opdata2_i}
                            : {{WIDTH{1'b0}}, w_dz ? opdata1_i : (op_i[1] ? w_m1 : w_m2)};
        end
        S_RUN: begin
          if (annul_i) r_state <= S_IDLE;
          else if (r_quick || r_cnt == CW'(WIDTH)) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_res   <= w_final;
            r_dz    <= r_quick & r_div;
          end else begin
            r_acc <= r_div ? w_div_nx : w_mul_nx;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy_o   = r_state != S_IDLE;
  assign ready_o  = r_ready;
  assign result_o = r_res;
  assign dz_o     = r_dz;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: randomized checks of muldiv_iter (WIDTH 32 and 16) against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_iter;
  logic clk = 0, rst = 1, start = 0, start16 = 0, annul = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic busy, ready, dz, busy16, ready16, dz16;
  logic [63:0] res;
  logic [31:0] res16;
  int n_tests = 0, n_fail = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  always #5 clk = ~clk;
  muldiv_iter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start_i(start), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .annul_i(annul), .busy_o(busy), .ready_o(ready),
    .result_o(res), .dz_o(dz));
  muldiv_iter #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start_i(start16), .op_i(op),
    .opdata1_i(a16), .opdata2_i(b16), .annul_i(annul), .busy_o(busy16), .ready_o(ready16),
    .result_o(res16), .dz_o(dz16));

  function automatic logic [63:0] ref_op(input int w, input logic [1:0] o, input logic [31:0] x, y);
    logic [63:0] mask, mask2, ux, uy, q, r;
    logic signed [63:0] sx, sy;
    mask  = (64'd1 << w) - 64'd1;
    mask2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 64'd1;
    ux = {32'b0, x} & mask;
    uy = {32'b0, y} & mask;
    sx = (ux ^ (64'd1 << (w - 1))) - (64'd1 << (w - 1));
    sy = (uy ^ (64'd1 << (w - 1))) - (64'd1 << (w - 1));
    if (o == 2'd0) return (ux * uy) & mask2;
    if (o == 2'd1) return (sx * sy) & mask2;
    if (uy == 0) return (ux << w) | mask;
    if (o == 2'd2) return ((ux % uy) << w) | (ux / uy);
    q = sx / sy;
    r = sx % sy;
    return ((r & mask) << w) | (q & mask);
  endfunction

  function automatic int exp_lat(input int w, input logic [1:0] o, input logic [31:0] y);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    if (o[1]) return ((y & m) == 0) ? 1 : w + 1;
    return FAST ? 1 : w + 1;
  endfunction

  task automatic do_op(input bit w16, input logic [1:0] o, input logic [31:0] x, y,
                       output logic [63:0] r, output logic d, output int lat);
    int g;
    g = 0;
    while ((w16 ? busy16 : busy) && g < 200) begin @(posedge clk); #1; g++; end
    @(negedge clk);
    op = o;
    if (w16) begin a16 = x[15:0]; b16 = y[15:0]; start16 = 1; end
    else begin a = x; b = y; start = 1; end
    @(posedge clk); #1;
    start = 0; start16 = 0; lat = 0;
    while (!(w16 ? ready16 : ready) && lat < 200) begin @(posedge clk); #1; lat++; end
    if (lat >= 200) lat = -1;
    r = w16 ? {32'b0, res16} : res;
    d = w16 ? dz16 : dz;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, ready, dz, res} !== 67'd0) begin
      n_fail++; $display("FAIL reset32 got busy=%b ready=%b dz=%b res=%h exp all 0", busy, ready, dz, res);
    end
    n_tests++;
    if ({busy16, ready16, dz16, res16} !== 35'd0) begin
      n_fail++; $display("FAIL reset16 got busy=%b ready=%b dz=%b res=%h exp all 0", busy16, ready16, dz16, res16);
    end
    rst = 0;
  endtask

  task automatic test_directed;
    logic [1:0] ops [6] = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] xs [6] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] ys [6] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'hFFFF_FFFF};
    logic [63:0] ex [6] = '{{32'd2, 32'd14}, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                            64'h0000_1234_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001};
    int lats [6] = '{33, 33, 33, 1, FAST ? 1 : 33, FAST ? 1 : 33};
    logic [63:0] r;
    logic d;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(0, ops[i], xs[i], ys[i], r, d, lat);
      n_tests++;
      if (r !== ex[i]) begin n_fail++; $display("FAIL dir%0d_res got=%h exp=%h", i, r, ex[i]); end
      n_tests++;
      if (d !== (i == 3)) begin n_fail++; $display("FAIL dir%0d_dz got=%b exp=%b", i, d, i == 3); end
      n_tests++;
      if (lat != lats[i]) begin n_fail++; $display("FAIL dir%0d_lat got=%0d exp=%0d", i, lat, lats[i]); end
    end
  endtask

  task automatic test_random;
    logic [63:0] r, e;
    logic [1:0] o;
    logic [31:0] x, y;
    logic d;
    int lat, w;
    for (int i = 0; i < 80; i++) begin
      w = (i < 60) ? 32 : 16;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: begin x = (w == 32) ? 32'h8000_0000 : 32'h8000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(1, 15);
        default: ;
      endcase
      e = ref_op(w, o, x, y);
      do_op(w == 16, o, x, y, r, d, lat);
      n_tests++;
      if (r !== e) begin n_fail++; $display("FAIL rand_res w=%0d op=%0d a=%h b=%h got=%h exp=%h", w, o, x, y, r, e); end
      n_tests++;
      if (d !== (o[1] && (exp_lat(w, o, y) == 1))) begin n_fail++; $display("FAIL rand_dz w=%0d op=%0d b=%h got=%b", w, o, y, d); end
      n_tests++;
      if (lat != exp_lat(w, o, y)) begin n_fail++; $display("FAIL rand_lat w=%0d op=%0d got=%0d exp=%0d", w, o, lat, exp_lat(w, o, y)); end
    end
  endtask

  task automatic test_annul;
    logic [63:0] prev, r, e;
    logic d, seen;
    int lat;
    do_op(0, 2'd2, 32'd50, 32'd5, prev, d, lat);
    @(posedge clk); #1;
    @(negedge clk);
    op = 2'd3; a = -32'd100; b = 32'd7; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1 annul = 1;
    @(posedge clk); #1;
    annul = 0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL annul_busy got=%b exp=0", busy); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= ready | busy; end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL annul_quiet got=%b exp=0", seen); end
    n_tests++;
    if (res !== ref_op(32, 2'd2, 32'd50, 32'd5)) begin n_fail++; $display("FAIL annul_hold got=%h exp=%h", res, ref_op(32, 2'd2, 32'd50, 32'd5)); end
    e = ref_op(32, 2'd2, 32'hDEAD_BEEF, 32'd1234);
    do_op(0, 2'd2, 32'hDEAD_BEEF, 32'd1234, r, d, lat);
    n_tests++;
    if (r !== e || lat != 33) begin n_fail++; $display("FAIL annul_next got=%h lat=%0d exp=%h lat=33", r, lat, e); end
    @(negedge clk);
    start = 1; annul = 1;
    @(posedge clk); #1;
    start = 0; annul = 0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL annul_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] prev;
    logic d, seen;
    int lat;
    do_op(0, 2'd2, 32'd1000, 32'd3, prev, d, lat);
    op = 2'd0; a = 32'hFFFF_FFFF; b = 32'h1234; start = 1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ignore got busy=%b ready=%b exp 0 0", busy, ready); end
    @(posedge clk); #1;
    start = 0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start got busy=%b exp=1", busy); end
    repeat (14) @(posedge clk);
    #1;
    n_tests++;
    if (res !== {32'd1, 32'd333} || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_hold got res=%h busy=%b exp=%h busy=1", res, busy, {32'd1, 32'd333}); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n_tests++;
    if ({busy, ready, dz, res} !== 67'd0) begin n_fail++; $display("FAIL b2b_reset got busy=%b ready=%b dz=%b res=%h exp all 0", busy, ready, dz, res); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= busy | ready; end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", seen); end
  endtask

  task automatic test_w16;
    logic [63:0] r;
    logic d;
    int lat;
    do_op(1, 2'd2, 32'd300, 32'd7, r, d, lat);
    n_tests++;
    if (r[31:0] !== {16'd6, 16'd42} || d !== 1'b0) begin n_fail++; $display("FAIL w16_div got=%h dz=%b exp=%h dz=0", r[31:0], d, {16'd6, 16'd42}); end
    n_tests++;
    if (lat != 17) begin n_fail++; $display("FAIL w16_lat got=%0d exp=17", lat); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_w16;
    test_random;
    test_annul;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
